mips_multi_ctrl: RTL and testbench

MIPS_MULTI_CTRL -- requirements
Module: mips_multi_ctrl

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mips_aludec.sv | 30 +++
 rtl/mips_multi_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mips_multi_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// FSM states, opcode/funct constants, ALU and mux select codes.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps aluop and the R-type funct field
// onto the 3-bit alucontrol code.
module mips_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multi-cycle MIPS control FSM with memory-wait timeout and HALT.
// Define MIPS_BNE_EN to decode bne (op 000101) as a branch.
module mips_multi_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       illegal,
    output logic       memerr,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    state_t           dec_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             wait_st;
    logic             expire;
    logic             legal;
    logic             take;
    logic             pcwrite;
    logic             branch;
    logic             irwrite_raw;
    logic             regwrite_raw;
    logic             memwrite_raw;
    logic [1:0]       aluop;

    assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // memready on the last tolerated cycle wins over the timeout
    assign expire = wait_st && !memready && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            count  <= '0;
            memerr <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state_next == HALT)
                memerr <= 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        if (wait_st && !memready && !expire)
            count_next = count + 1'b1;
    end

    always_comb begin
        dec_next = FETCH;
        legal    = 1'b1;
        case (op)
            OP_LW, OP_SW: dec_next = MEMADR;
            OP_RTYPE: begin
                if (funct_ok(funct))
                    dec_next = EXECUTE;
                else
                    legal = 1'b0;
            end
            OP_BEQ:  dec_next = BRANCH;
`ifdef MIPS_BNE_EN
            OP_BNE:  dec_next = BRANCH;
`endif
            OP_ADDI: dec_next = ADDIEX;
            OP_J:    dec_next = JUMP;
            default: legal = 1'b0;
        endcase
    end

`ifdef MIPS_BNE_EN
    assign take = (op == OP_BNE) ? ~zero : zero;
`else
    assign take = zero;
`endif

    always_comb begin
        state_next   = state;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        alusrca      = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        illegal      = 1'b0;
        alusrcb      = SRCB_REG;
        pcsrc        = PC_ALU;
        aluop        = ALUOP_ADD;
        case (state)
            FETCH: begin
                alusrcb = SRCB_FOUR;
                if (memready) begin
                    irwrite_raw = 1'b1;
                    pcwrite     = 1'b1;
                    state_next  = DECODE;
                end else if (expire) begin
                    state_next = HALT;
                end
            end
            DECODE: begin
                alusrcb    = SRCB_BRIMM;
                illegal    = !legal;
                state_next = dec_next;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (memready)
                    state_next = MEMWB;
                else if (expire)
                    state_next = HALT;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = FETCH;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                if (memready)
                    state_next = FETCH;
                else if (expire)
                    state_next = HALT;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PC_ALUOUT;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                state_next   = FETCH;
            end
            JUMP: begin
                pcsrc      = PC_JUMP;
                pcwrite    = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // enables are masked while reset is low, even mid-instruction
    assign pcen     = reset & (pcwrite | (branch & take));
    assign irwrite  = reset & irwrite_raw;
    assign regwrite = reset & regwrite_raw;
    assign memwrite = reset & memwrite_raw;

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: latency table, directed corner cases,
// and random instruction streams against a step-list reference model.
module tb_mips_multi_ctrl;

    localparam int TO = 4;
`ifdef MIPS_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       memready = 1'b0;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord;
    logic       memtoreg, regdst, illegal, memerr;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    mips_multi_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .memready(memready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .illegal(illegal),
        .memerr(memerr), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcen, memwrite, irwrite, regwrite, alusrca;
        logic       iord, memtoreg, regdst, illegal, memerr;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
    } out_t;

    out_t act;
    assign act = {pcen, memwrite, irwrite, regwrite, alusrca, iord,
                  memtoreg, regdst, illegal, memerr, alusrcb, pcsrc,
                  alucontrol};

    typedef enum int {S_F, S_D, S_A, S_R, S_RW, S_W, S_E, S_EW,
                      S_B, S_I, S_IW, S_J, S_H} step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cyc;
        int         pc;
        int         rw;
        int         mw;
        int         il;
    } vec_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    mw_hits, rwm_hits, rwm_at, inst_cyc;
    step_t plan[$];
    bit    mrq[$];
    vec_t  tbl[12];

    function automatic bit r_ok(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 ||
               f == 6'h25 || f == 6'h2a;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_br(input logic [5:0] o);
        return o == 6'h04 || (BNE_EN && o == 6'h05);
    endfunction

    function automatic bit legal_op(input logic [5:0] o, input logic [5:0] f);
        return o == 6'h23 || o == 6'h2b || o == 6'h08 || o == 6'h02 ||
               is_br(o) || (o == 6'h00 && r_ok(f));
    endfunction

    // sequence of control steps an instruction walks through
    function automatic void make_plan(input logic [5:0] o, input logic [5:0] f);
        plan = {S_F, S_D};
        if (!legal_op(o, f)) return;
        if (o == 6'h23) begin
            plan.push_back(S_A); plan.push_back(S_R); plan.push_back(S_RW);
        end else if (o == 6'h2b) begin
            plan.push_back(S_A); plan.push_back(S_W);
        end else if (o == 6'h00) begin
            plan.push_back(S_E); plan.push_back(S_EW);
        end else if (o == 6'h08) begin
            plan.push_back(S_I); plan.push_back(S_IW);
        end else if (o == 6'h02) begin
            plan.push_back(S_J);
        end else begin
            plan.push_back(S_B);
        end
    endfunction

    function automatic out_t expect_out(input step_t s, input logic [5:0] o,
                                        input logic [5:0] f, input logic z,
                                        input logic mr);
        out_t e;
        e = '0;
        e.alucontrol = 3'b010;
        case (s)
            S_F:  begin e.alusrcb = 2'b01; e.pcen = mr; e.irwrite = mr; end
            S_D:  begin e.alusrcb = 2'b11; e.illegal = !legal_op(o, f); end
            S_A:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_R:  e.iord = 1'b1;
            S_RW: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            S_W:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            S_E:  begin e.alusrca = 1'b1; e.alucontrol = r_alu(f); end
            S_EW: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            S_B: begin
                e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                e.pcen = (o == 6'h05) ? !z : z;
            end
            S_I:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_IW: e.regwrite = 1'b1;
            S_J:  begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            S_H:  e.memerr = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string nm, input out_t e);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s: outputs got %h required %h", nm, act, e);
        end
        if (act.memwrite) mw_hits++;
        if (act.regwrite && act.memtoreg) begin
            rwm_hits++;
            rwm_at = inst_cyc;
        end
        inst_cyc++;
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, a, e);
        end
    endtask

    task automatic cycle(input step_t s, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic mr, input string nm);
        op = o; funct = f; zero = z; memready = mr;
        #1;
        check(nm, expect_out(s, o, f, z, mr));
        @(posedge clk);
        #1;
    endtask

    // from_q: memready taken from mrq in wait steps (1 once empty)
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input bit from_q, input string nm);
        int zrun;
        bit mr;
        make_plan(o, f);
        inst_cyc = 0; mw_hits = 0; rwm_hits = 0; rwm_at = -1;
        for (int i = 0; i < plan.size(); i++) begin
            if (plan[i] == S_F || plan[i] == S_R || plan[i] == S_W) begin
                zrun = 0;
                forever begin
                    if (from_q)
                        mr = (mrq.size() > 0) ? mrq.pop_front() : 1'b1;
                    else
                        mr = (zrun >= TO - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    cycle(plan[i], o, f, z, mr, nm);
                    if (mr) break;
                    zrun++;
                    if (zrun == TO) begin
                        cycle(S_H, o, f, z, 1'b0, nm);
                        cycle(S_H, o, f, z, 1'b1, nm);
                        return;
                    end
                end
            end else begin
                cycle(plan[i], o, f, z, 1'($urandom_range(0, 1)), nm);
            end
        end
    endtask

    task automatic apply_reset(input string nm);
        out_t e;
        e = '0;
        e.alusrcb = 2'b01;
        e.alucontrol = 3'b010;
        memready = 1'b1;
        reset = 1'b0;
        #1;
        check(nm, e);
        @(posedge clk);
        #1;
        check(nm, e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_int({nm, " first fetch irwrite"}, int'(irwrite), 1);
    endtask

    task automatic measure(input vec_t v, input int idx);
        int c, npc, nrw, nmw, nil;
        op = v.op; funct = v.funct; zero = v.zero; memready = 1'b1;
        c = 0; npc = 0; nrw = 0; nmw = 0; nil = 0;
        do begin
            #1;
            npc += int'(pcen); nrw += int'(regwrite);
            nmw += int'(memwrite); nil += int'(illegal);
            @(posedge clk);
            #1;
            c++;
        end while (alusrcb != 2'b01 && c < 10);
        chk_int($sformatf("tbl%0d latency", idx), c, v.cyc);
        chk_int($sformatf("tbl%0d pcen cycles", idx), npc, v.pc);
        chk_int($sformatf("tbl%0d regwrite cycles", idx), nrw, v.rw);
        chk_int($sformatf("tbl%0d memwrite cycles", idx), nmw, v.mw);
        chk_int($sformatf("tbl%0d illegal cycles", idx), nil, v.il);
    endtask

    logic [5:0] rops [8];

    initial begin
        tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 1, 1, 0, 0};
        tbl[1]  = '{6'h2b, 6'h00, 1'b0, 4, 1, 0, 1, 0};
        tbl[2]  = '{6'h00, 6'h20, 1'b0, 4, 1, 1, 0, 0};
        tbl[3]  = '{6'h00, 6'h2a, 1'b1, 4, 1, 1, 0, 0};
        tbl[4]  = '{6'h00, 6'h00, 1'b0, 2, 1, 0, 0, 1};
        tbl[5]  = '{6'h04, 6'h00, 1'b1, 3, 2, 0, 0, 0};
        tbl[6]  = '{6'h04, 6'h00, 1'b0, 3, 1, 0, 0, 0};
        tbl[7]  = '{6'h08, 6'h11, 1'b0, 4, 1, 1, 0, 0};
        tbl[8]  = '{6'h02, 6'h00, 1'b0, 3, 2, 0, 0, 0};
        tbl[9]  = '{6'h3f, 6'h00, 1'b0, 2, 1, 0, 0, 1};
`ifdef MIPS_BNE_EN
        tbl[10] = '{6'h05, 6'h00, 1'b0, 3, 2, 0, 0, 0};
        tbl[11] = '{6'h05, 6'h00, 1'b1, 3, 1, 0, 0, 0};
`else
        tbl[10] = '{6'h05, 6'h00, 1'b0, 2, 1, 0, 0, 1};
        tbl[11] = '{6'h05, 6'h00, 1'b1, 2, 1, 0, 0, 1};
`endif
        rops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};

        apply_reset("reset state");

        for (int i = 0; i < 12; i++)
            measure(tbl[i], i);

        mrq = {};
        run(6'h23, 6'h00, 1'b0, 1'b1, "lw ready");
        chk_int("lw memtoreg writes", rwm_hits, 1);
        chk_int("lw writeback cycle", rwm_at, 4);

        mrq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run(6'h2b, 6'h00, 1'b0, 1'b1, "sw wait3");
        chk_int("sw memwrite cycles", mw_hits, 4);

        mrq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run(6'h23, 6'h00, 1'b0, 1'b1, "lw ready wins");
        run(6'h04, 6'h00, 1'b1, 1'b1, "beq taken");
        run(6'h04, 6'h00, 1'b0, 1'b1, "beq not taken");
        run(6'h05, 6'h00, 1'b0, 1'b1, "bne zero0");

        mrq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run(6'h2b, 6'h00, 1'b0, 1'b1, "sw timeout");
        apply_reset("reset after halt");

        mrq = {1'b0, 1'b0, 1'b0, 1'b0};
        run(6'h23, 6'h00, 1'b0, 1'b1, "fetch timeout");
        apply_reset("reset clears memerr");

        cycle(S_F, 6'h00, 6'h22, 1'b0, 1'b1, "exec reset");
        cycle(S_D, 6'h00, 6'h22, 1'b0, 1'b1, "exec reset");
        #1;
        check("exec reset", expect_out(S_E, 6'h00, 6'h22, 1'b0, 1'b1));
        apply_reset("reset in execute");

        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            o = rops[$urandom_range(0, 7)];
            if (n % 7 == 6) o = 6'($urandom);
            f = ($urandom_range(0, 3) != 0) ? 6'h20 + 6'($urandom_range(0, 10))
                                            : 6'($urandom);
            run(o, f, 1'($urandom_range(0, 1)), 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
